// File: rtl/tiny_oram_multiport.sv
// Round-robin multi-client front door for the TinyORAM core user interface.
// One block transaction at a time; each client's address space is prefixed by its port index.
module tiny_oram_multiport #(
    parameter  int unsigned NumPorts   = 4,
    parameter  int unsigned ORAMU      = 32,
    parameter  int unsigned ORAMB      = 512,
    parameter  int unsigned FEDWidth   = 64,
    parameter  int unsigned BECMDWidth = 2,
    localparam int unsigned PW         = $clog2(NumPorts),
    localparam int unsigned PAW        = ORAMU - PW,
    localparam int unsigned BlkBeats   = ORAMB / FEDWidth
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NumPorts*BECMDWidth-1:0] PortCmd,
    input  logic [NumPorts*PAW-1:0]        PortPAddr,
    input  logic [NumPorts-1:0]            PortCmdValid,
    output logic [NumPorts-1:0]            PortCmdReady,
    input  logic [NumPorts*FEDWidth-1:0]   PortDataIn,
    input  logic [NumPorts-1:0]            PortDataInValid,
    output logic [NumPorts-1:0]            PortDataInReady,
    output logic [FEDWidth-1:0]            PortDataOut,
    output logic [NumPorts-1:0]            PortDataOutValid,
    input  logic [NumPorts-1:0]            PortDataOutReady,
    output logic [BECMDWidth-1:0]          Cmd,
    output logic [ORAMU-1:0]               PAddr,
    output logic                           CmdValid,
    input  logic                           CmdReady,
    output logic [FEDWidth-1:0]            DataIn,
    output logic                           DataInValid,
    input  logic                           DataInReady,
    input  logic [FEDWidth-1:0]            DataOut,
    input  logic                           DataOutValid,
    output logic                           DataOutReady,
    output logic [NumPorts-1:0]            Grant,
    output logic                           Busy
);
    localparam int unsigned    BCW      = $clog2(BlkBeats) + 1;
    localparam logic [BCW-1:0] LastBeat = BCW'(BlkBeats - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [NumPorts-1:0] grant_q, grant_d;
    logic [BCW-1:0]      beat_q, beat_d;

    logic [BECMDWidth-1:0] cmd_a   [NumPorts];
    logic [PAW-1:0]        paddr_a [NumPorts];
    logic [FEDWidth-1:0]   din_a   [NumPorts];

    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cmd_a[i]   = PortCmd[i*BECMDWidth +: BECMDWidth];
            paddr_a[i] = PortPAddr[i*PAW +: PAW];
            din_a[i]   = PortDataIn[i*FEDWidth +: FEDWidth];
        end
    end

    // First valid port at or after the round-robin pointer; index arithmetic wraps mod NumPorts.
    logic          win_vld;
    logic [PW-1:0] win_idx;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (!win_vld && PortCmdValid[rr_q + PW'(k)]) begin
                win_vld = 1'b1;
                win_idx = rr_q + PW'(k);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        gidx_d           = gidx_q;
        rr_d             = rr_q;
        grant_d          = grant_q;
        beat_d           = beat_q;
        Cmd              = '0;
        PAddr            = '0;
        CmdValid         = 1'b0;
        PortCmdReady     = '0;
        DataIn           = '0;
        DataInValid      = 1'b0;
        PortDataInReady  = '0;
        PortDataOut      = '0;
        PortDataOutValid = '0;
        DataOutReady     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_CMD;
                    gidx_d  = win_idx;
                    grant_d = {{(NumPorts-1){1'b0}}, 1'b1} << win_idx;
                    rr_d    = win_idx + 1'b1;
                end
            end
            S_CMD: begin
                Cmd                  = cmd_a[gidx_q];
                PAddr                = {gidx_q, paddr_a[gidx_q]};
                CmdValid             = PortCmdValid[gidx_q];
                PortCmdReady[gidx_q] = CmdReady;
                if (PortCmdValid[gidx_q] && CmdReady) begin
                    beat_d  = '0;
                    // Update/Append are writes; Read/ReadRmv are reads.
                    state_d = (cmd_a[gidx_q] < BECMDWidth'(2)) ? S_WR : S_RD;
                end
            end
            S_WR: begin
                DataIn                  = din_a[gidx_q];
                DataInValid             = PortDataInValid[gidx_q];
                PortDataInReady[gidx_q] = DataInReady;
                if (PortDataInValid[gidx_q] && DataInReady) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            S_RD: begin
                PortDataOut              = DataOut;
                PortDataOutValid[gidx_q] = DataOutValid;
                DataOutReady             = PortDataOutReady[gidx_q];
                if (DataOutValid && PortDataOutReady[gidx_q]) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

    assign Grant = grant_q;
    assign Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_tiny_oram_multiport.sv
// Scoreboard bench for tiny_oram_multiport: directed client/core traffic, in-order expectation queues.
module tb_tiny_oram_multiport;
    logic         Clock;
    logic         Reset;
    logic [7:0]   PortCmd;
    logic [119:0] PortPAddr;
    logic [3:0]   PortCmdValid;
    logic [3:0]   PortCmdReady;
    logic [255:0] PortDataIn;
    logic [3:0]   PortDataInValid;
    logic [3:0]   PortDataInReady;
    logic [63:0]  PortDataOut;
    logic [3:0]   PortDataOutValid;
    logic [3:0]   PortDataOutReady;
    logic [1:0]   Cmd;
    logic [31:0]  PAddr;
    logic         CmdValid;
    logic         CmdReady;
    logic [63:0]  DataIn;
    logic         DataInValid;
    logic         DataInReady;
    logic [63:0]  DataOut;
    logic         DataOutValid;
    logic         DataOutReady;
    logic [3:0]   Grant;
    logic         Busy;

    tiny_oram_multiport #(
        .NumPorts   (4),
        .ORAMU      (32),
        .ORAMB      (512),
        .FEDWidth   (64),
        .BECMDWidth (2)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .PortCmd          (PortCmd),
        .PortPAddr        (PortPAddr),
        .PortCmdValid     (PortCmdValid),
        .PortCmdReady     (PortCmdReady),
        .PortDataIn       (PortDataIn),
        .PortDataInValid  (PortDataInValid),
        .PortDataInReady  (PortDataInReady),
        .PortDataOut      (PortDataOut),
        .PortDataOutValid (PortDataOutValid),
        .PortDataOutReady (PortDataOutReady),
        .Cmd              (Cmd),
        .PAddr            (PAddr),
        .CmdValid         (CmdValid),
        .CmdReady         (CmdReady),
        .DataIn           (DataIn),
        .DataInValid      (DataInValid),
        .DataInReady      (DataInReady),
        .DataOut          (DataOut),
        .DataOutValid     (DataOutValid),
        .DataOutReady     (DataOutReady),
        .Grant            (Grant),
        .Busy             (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [63:0] val;
        logic [3:0]  who;
    } exp_t;

    exp_t        exp_cmd[$];
    exp_t        exp_wr[$];
    exp_t        exp_rd[$];
    exp_t        mon_e;
    logic [63:0] core_q[$];

    int compared   = 0;
    int mismatched = 0;

    // Client-side and core-side model state.
    bit          cmd_pend    [4];
    logic [1:0]  cmd_kind    [4];
    logic [29:0] addr_a      [4];
    int          wr_left     [4];
    int          wr_idx      [4];
    int          rd_left     [4];
    int          rd_idx      [4];
    int          wstall_at   [4];
    int          wstall_len  [4];
    int          wstall_rem  [4];
    int          rstall_at   [4];
    int          rstall_len  [4];
    int          rstall_rem  [4];
    int          din_rdy_cnt [4];
    bit          core_stray;

    logic       s_cmdvalid;
    logic [3:0] s_grant;
    logic       s_busy;
    logic       s_dor;
    logic [3:0] s_pdov;

    function automatic logic [63:0] wr_val(input int p, input int j);
        return 64'hA5A5_0000_0000_0000 + 64'(p * 256 + j);
    endfunction

    function automatic logic [63:0] rd_val(input int p, input int j);
        return 64'hC0DE_0000_0000_0000 + 64'(p * 256 + j);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset) begin
            if (CmdValid && CmdReady) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", {30'b0, Cmd, PAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    check("cmd_paddr", {30'b0, Cmd, PAddr}, mon_e.val);
                    check("cmd_grant", 64'(Grant), 64'(mon_e.who));
                end
            end
            if (DataInValid && DataInReady) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", DataIn, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_data", DataIn, mon_e.val);
                    check("wr_grant", 64'(Grant), 64'(mon_e.who));
                end
            end
            if (|(PortDataOutValid & PortDataOutReady)) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", PortDataOut, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_rd.pop_front();
                    check("rd_data", PortDataOut, mon_e.val);
                    check("rd_port", 64'(PortDataOutValid), 64'(mon_e.who));
                end
            end
        end
    end

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            PortCmdValid[p]         = cmd_pend[p];
            PortCmd[p*2 +: 2]       = cmd_kind[p];
            PortPAddr[p*30 +: 30]   = addr_a[p];
            PortDataInValid[p]      = (wr_left[p] > 0) && (wstall_rem[p] == 0);
            PortDataIn[p*64 +: 64]  = wr_val(p, wr_idx[p]);
            PortDataOutReady[p]     = (rstall_rem[p] == 0);
        end
        CmdReady     = 1'b1;
        DataInReady  = 1'b1;
        DataOutValid = core_stray || (core_q.size() > 0);
        DataOut      = (core_q.size() > 0) ? core_q[0] : 64'hDEAD_DEAD_DEAD_DEAD;
    endtask

    task automatic clear_state();
        for (int p = 0; p < 4; p++) begin
            cmd_pend[p]   = 1'b0;
            cmd_kind[p]   = 2'd0;
            addr_a[p]     = '0;
            wr_left[p]    = 0;
            wr_idx[p]     = 0;
            rd_left[p]    = 0;
            rd_idx[p]     = 0;
            wstall_at[p]  = -1;
            wstall_len[p] = 0;
            wstall_rem[p] = 0;
            rstall_at[p]  = -1;
            rstall_len[p] = 0;
            rstall_rem[p] = 0;
        end
        core_stray = 1'b0;
        core_q.delete();
        exp_cmd.delete();
        exp_wr.delete();
        exp_rd.delete();
    endtask

    function automatic bit all_done();
        for (int p = 0; p < 4; p++)
            if (cmd_pend[p] || wr_left[p] > 0 || rd_left[p] > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic issue(input int p, input logic [1:0] c, input logic [29:0] a,
                         input logic [31:0] exp_paddr);
        logic [3:0] m;
        m = 4'b0001 << p;
        cmd_pend[p] = 1'b1;
        cmd_kind[p] = c;
        addr_a[p]   = a;
        exp_cmd.push_back('{val: {30'b0, c, exp_paddr}, who: m});
        if (c < 2'd2) begin
            wr_left[p] = 8;
            wr_idx[p]  = 0;
            for (int j = 0; j < 8; j++) exp_wr.push_back('{val: wr_val(p, j), who: m});
        end else begin
            rd_left[p] = 8;
            rd_idx[p]  = 0;
            for (int j = 0; j < 8; j++) exp_rd.push_back('{val: rd_val(p, j), who: m});
        end
        drive();
    endtask

    task automatic cycle();
        bit         chs, whs, rhs;
        logic [3:0] g;
        @(negedge Clock);
        chs        = CmdValid && CmdReady;
        whs        = DataInValid && DataInReady;
        rhs        = DataOutValid && DataOutReady;
        g          = Grant;
        s_cmdvalid = CmdValid;
        s_grant    = Grant;
        s_busy     = Busy;
        s_dor      = DataOutReady;
        s_pdov     = PortDataOutValid;
        for (int p = 0; p < 4; p++) begin
            if (PortDataInReady[p]) din_rdy_cnt[p]++;
            if (g[p] && wr_left[p] > 0 && !cmd_pend[p] && wstall_rem[p] > 0) begin
                check("stall_datainvalid", 64'(DataInValid), 64'd0);
                check("stall_busy", 64'(Busy), 64'd1);
            end
            if (g[p] && rd_left[p] > 0 && !cmd_pend[p] && rstall_rem[p] > 0)
                check("stall_dataoutready", 64'(DataOutReady), 64'd0);
        end
        @(posedge Clock);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (wstall_rem[p] > 0) wstall_rem[p]--;
            if (rstall_rem[p] > 0) rstall_rem[p]--;
        end
        if (chs) begin
            for (int p = 0; p < 4; p++) begin
                if (g[p] && cmd_pend[p]) begin
                    cmd_pend[p] = 1'b0;
                    if (cmd_kind[p] >= 2'd2)
                        for (int j = 0; j < 8; j++) core_q.push_back(rd_val(p, j));
                end
            end
        end
        if (whs) begin
            for (int p = 0; p < 4; p++) begin
                if (g[p] && wr_left[p] > 0) begin
                    wr_idx[p]++;
                    wr_left[p]--;
                    if (wr_idx[p] == wstall_at[p]) begin
                        wstall_rem[p] = wstall_len[p];
                        wstall_at[p]  = -1;
                    end
                end
            end
        end
        if (rhs) begin
            if (core_q.size() > 0) void'(core_q.pop_front());
            for (int p = 0; p < 4; p++) begin
                if (g[p] && rd_left[p] > 0) begin
                    rd_idx[p]++;
                    rd_left[p]--;
                    if (rd_idx[p] == rstall_at[p]) begin
                        rstall_rem[p] = rstall_len[p];
                        rstall_at[p]  = -1;
                    end
                end
            end
        end
        drive();
    endtask

    task automatic run(input string tag, input int unsigned max_cycles, output int unsigned n);
        n = 0;
        while (!all_done() && n < max_cycles) begin
            cycle();
            n++;
        end
        if (!all_done()) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            clear_state();
            drive();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(Grant), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_cmdvalid"}, 64'(CmdValid), 64'd0);
        check({tag, "_datainvalid"}, 64'(DataInValid), 64'd0);
        check({tag, "_dataoutready"}, 64'(DataOutReady), 64'd0);
        check({tag, "_portcmdready"}, 64'(PortCmdReady), 64'd0);
        check({tag, "_portdatainready"}, 64'(PortDataInReady), 64'd0);
        check({tag, "_portdataoutvalid"}, 64'(PortDataOutValid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the bench ended");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        Reset = 1'b0;
        clear_state();
        for (int p = 0; p < 4; p++) din_rdy_cnt[p] = 0;
        drive();
        #1;
        check_all_zero("rst");
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        cycle();
        check("idle_busy", 64'(s_busy), 64'd0);
        check("idle_grant", 64'(s_grant), 64'd0);

        // Stray core load data while idle must be back-pressured.
        core_stray = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stray_dataoutready", 64'(s_dor), 64'd0);
            check("stray_portdataoutvalid", 64'(s_pdov), 64'd0);
        end
        core_stray = 1'b0;
        drive();

        // Single Read on port 2.
        issue(2, 2'd2, 30'h1234, 32'h8000_1234);
        cycle();
        check("lat_cmdvalid_idle", 64'(s_cmdvalid), 64'd0);
        cycle();
        check("lat_cmdvalid_cmd", 64'(s_cmdvalid), 64'd1);
        check("lat_grant", 64'(s_grant), 64'h4);
        run("read_p2", 100, n);
        cycle();
        check("read_p2_busy_after", 64'(s_busy), 64'd0);
        check("read_p2_grant_after", 64'(s_grant), 64'd0);

        // All four ports Update together straight from reset.
        Reset = 1'b0;
        clear_state();
        drive();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int p = 0; p < 4; p++) din_rdy_cnt[p] = 0;
        issue(0, 2'd0, 30'h10, 32'h0000_0010);
        issue(1, 2'd0, 30'h11, 32'h4000_0011);
        issue(2, 2'd0, 30'h12, 32'h8000_0012);
        issue(3, 2'd0, 30'h13, 32'hC000_0013);
        run("update_all", 200, n);
        cycle();
        check("din_ready_pulses_p0", 64'(din_rdy_cnt[0]), 64'd8);
        check("din_ready_pulses_p1", 64'(din_rdy_cnt[1]), 64'd8);
        check("din_ready_pulses_p2", 64'(din_rdy_cnt[2]), 64'd8);
        check("din_ready_pulses_p3", 64'(din_rdy_cnt[3]), 64'd8);

        // Port 1 Append with a 5-cycle data stall after beat 3: 1 + 1 + 8 + 5 cycles.
        wstall_at[1]  = 3;
        wstall_len[1] = 5;
        issue(1, 2'd1, 30'h2_ABCD, 32'h4002_ABCD);
        run("append_p1", 100, n);
        check("append_p1_cycles", 64'(n), 64'd15);
        cycle();
        check("append_p1_busy_after", 64'(s_busy), 64'd0);

        // Port 3 Read with client load back-pressure for 10 cycles after beat 2.
        rstall_at[3]  = 2;
        rstall_len[3] = 10;
        issue(3, 2'd2, 30'h0BEEF, 32'hC000_BEEF);
        run("read_p3", 100, n);
        check("read_p3_cycles", 64'(n), 64'd20);
        cycle();

        // Reset during write beat 4, then port 0 must beat port 3 because the pointer is cleared.
        issue(2, 2'd0, 30'h77, 32'h8000_0077);
        n = 0;
        while (wr_idx[2] < 4 && n < 40) begin
            cycle();
            n++;
        end
        check("abort_progress", 64'(wr_idx[2]), 64'd4);
        check("abort_pre_busy", 64'(Busy), 64'd1);
        Reset = 1'b0;
        #1;
        check_all_zero("abort");
        clear_state();
        drive();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        issue(0, 2'd0, 30'h5, 32'h0000_0005);
        issue(3, 2'd2, 30'h6, 32'hC000_0006);
        run("post_abort", 100, n);
        cycle();
        check("post_abort_busy", 64'(s_busy), 64'd0);

        check("exp_cmd_drained", 64'(exp_cmd.size()), 64'd0);
        check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
        check("exp_rd_drained", 64'(exp_rd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
